// File: rtl/tl_inflight_monitor.sv
// rtl/tl_inflight_monitor.sv - TileLink A/D in-flight tracker and protocol checker
module tl_inflight_monitor #(
   parameter int SOURCE_BITS = 2,
   parameter int SIZE_BITS   = 3,
   parameter int ADDR_BITS   = 30,
   parameter int BEAT_LOG2   = 2,
   parameter int TIMEOUT     = 1024
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        a_valid,
   input  logic                        a_ready,
   input  logic [2:0]                  a_opcode,
   input  logic [SIZE_BITS-1:0]        a_size,
   input  logic [SOURCE_BITS-1:0]      a_source,
   input  logic [ADDR_BITS-1:0]        a_address,
   input  logic                        d_valid,
   input  logic                        d_ready,
   input  logic [2:0]                  d_opcode,
   input  logic [SIZE_BITS-1:0]        d_size,
   input  logic [SOURCE_BITS-1:0]      d_source,
   output logic                        err_valid,
   output logic [3:0]                  err_code,
   output logic [8:0]                  err_flags,
   output logic [(2**SOURCE_BITS)-1:0] inflight,
   output logic                        idle
);
   localparam int NSRC  = 2 ** SOURCE_BITS;
   localparam int CNT_W = 2 ** SIZE_BITS;
   localparam int TO_W  = $clog2(TIMEOUT + 1);

   function automatic logic [CNT_W-1:0] beats_f(input logic [SIZE_BITS-1:0] size);
      if (int'(size) > BEAT_LOG2) return CNT_W'(1) << (int'(size) - BEAT_LOG2);
      return CNT_W'(1);
   endfunction

   logic                   a_fire, d_fire, a_first, d_first, d_last, d_chk, idle_w;
   logic [CNT_W-1:0]       a_beats, d_beats, a_cnt_q, a_cnt_d, d_cnt_q, d_cnt_d;
   logic [NSRC-1:0]        inflight_q, inflight_d;
   logic [2:0]             tbl_op_q [NSRC];
   logic [SIZE_BITS-1:0]   tbl_size_q [NSRC];
   logic [2:0]             a_bop_q, d_bop_q, a_pop_q, d_pop_q;
   logic [SIZE_BITS-1:0]   a_bsize_q, d_bsize_q, a_psize_q, d_psize_q;
   logic [SOURCE_BITS-1:0] a_bsrc_q, d_bsrc_q, a_psrc_q, d_psrc_q;
   logic [ADDR_BITS-1:0]   a_paddr_q, align_mask;
   logic                   a_hold_q, d_hold_q;
   logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
   logic [8:0]             errs;
   logic [3:0]             code_d;
   logic                   err_valid_q;
   logic [3:0]             err_code_q;
   logic [8:0]             err_flags_q;

   always_comb begin
      a_fire  = a_valid & a_ready;
      d_fire  = d_valid & d_ready;
      idle_w  = (inflight_q == '0);
      a_beats = (a_opcode == 3'd0 || a_opcode == 3'd1) ? beats_f(a_size) : CNT_W'(1);
      d_beats = (d_opcode == 3'd1) ? beats_f(d_size) : CNT_W'(1);
      a_first = (a_cnt_q == '0);
      d_first = (d_cnt_q == '0);
      d_last  = (d_beats == CNT_W'(1)) || (d_cnt_q == CNT_W'(1));

      a_cnt_d = a_cnt_q;
      if (a_fire) a_cnt_d = a_first ? a_beats - CNT_W'(1) : a_cnt_q - CNT_W'(1);
      d_cnt_d = d_cnt_q;
      if (d_fire) d_cnt_d = d_first ? d_beats - CNT_W'(1) : d_cnt_q - CNT_W'(1);

      // clear before set so a same-source collision leaves the bit set
      inflight_d = inflight_q;
      if (d_fire && d_last) inflight_d[d_source] = 1'b0;
      if (a_fire && a_first) inflight_d[a_source] = 1'b1;

      to_cnt_d = to_cnt_q;
      if (d_fire || idle_w) to_cnt_d = '0;
      else if (to_cnt_q != TO_W'(TIMEOUT)) to_cnt_d = to_cnt_q + TO_W'(1);

      align_mask = (ADDR_BITS'(1) << a_size) - ADDR_BITS'(1);
      d_chk      = d_fire & d_first & inflight_q[d_source];

      errs    = '0;
      errs[0] = a_fire & a_first & inflight_q[a_source];
      errs[1] = d_fire & d_first & ~inflight_q[d_source];
      errs[2] = d_chk & ((tbl_op_q[d_source] == 3'd4) ? (d_opcode != 3'd1) : (d_opcode != 3'd0));
      errs[3] = d_chk & (d_size != tbl_size_q[d_source]);
      errs[4] = a_fire & ((a_address & align_mask) != '0);
      errs[5] = a_hold_q & (~a_valid | (a_opcode != a_pop_q) | (a_size != a_psize_q) |
                            (a_source != a_psrc_q) | (a_address != a_paddr_q));
      errs[6] = d_hold_q & (~d_valid | (d_opcode != d_pop_q) | (d_size != d_psize_q) |
                            (d_source != d_psrc_q));
      errs[7] = (a_fire & ~a_first & ((a_opcode != a_bop_q) | (a_size != a_bsize_q) |
                                      (a_source != a_bsrc_q))) |
                (d_fire & ~d_first & ((d_opcode != d_bop_q) | (d_size != d_bsize_q) |
                                      (d_source != d_bsrc_q)));
      errs[8] = ~idle_w & ~d_fire & (to_cnt_q == TO_W'(TIMEOUT - 1));

      code_d = '0;
      for (int i = 8; i >= 0; i--) if (errs[i]) code_d = 4'(i + 1);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         a_cnt_q     <= '0;
         d_cnt_q     <= '0;
         inflight_q  <= '0;
         to_cnt_q    <= '0;
         for (int i = 0; i < NSRC; i++) begin
            tbl_op_q[i]   <= '0;
            tbl_size_q[i] <= '0;
         end
         a_bop_q     <= '0;
         a_bsize_q   <= '0;
         a_bsrc_q    <= '0;
         d_bop_q     <= '0;
         d_bsize_q   <= '0;
         d_bsrc_q    <= '0;
         a_hold_q    <= 1'b0;
         d_hold_q    <= 1'b0;
         a_pop_q     <= '0;
         a_psize_q   <= '0;
         a_psrc_q    <= '0;
         a_paddr_q   <= '0;
         d_pop_q     <= '0;
         d_psize_q   <= '0;
         d_psrc_q    <= '0;
         err_valid_q <= 1'b0;
         err_code_q  <= '0;
         err_flags_q <= '0;
      end else begin
         a_cnt_q    <= a_cnt_d;
         d_cnt_q    <= d_cnt_d;
         inflight_q <= inflight_d;
         to_cnt_q   <= to_cnt_d;
         if (a_fire && a_first) begin
            tbl_op_q[a_source]   <= a_opcode;
            tbl_size_q[a_source] <= a_size;
            a_bop_q              <= a_opcode;
            a_bsize_q            <= a_size;
            a_bsrc_q             <= a_source;
         end
         if (d_fire && d_first) begin
            d_bop_q   <= d_opcode;
            d_bsize_q <= d_size;
            d_bsrc_q  <= d_source;
         end
         a_hold_q    <= a_valid & ~a_ready;
         a_pop_q     <= a_opcode;
         a_psize_q   <= a_size;
         a_psrc_q    <= a_source;
         a_paddr_q   <= a_address;
         d_hold_q    <= d_valid & ~d_ready;
         d_pop_q     <= d_opcode;
         d_psize_q   <= d_size;
         d_psrc_q    <= d_source;
         err_valid_q <= |errs;
         err_code_q  <= code_d;
         err_flags_q <= err_flags_q | errs;
      end
   end

   assign err_valid = err_valid_q;
   assign err_code  = err_code_q;
   assign err_flags = err_flags_q;
   assign inflight  = inflight_q;
   assign idle      = idle_w;
endmodule

// File: tb/tb_tl_inflight_monitor.sv
// tb/tb_tl_inflight_monitor.sv - randomized and directed checks against a transaction-level model
module tb_tl_inflight_monitor;
   localparam int TIMEOUT   = 1024;
   localparam int BEAT_LOG2 = 2;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        a_valid = 1'b0, a_ready = 1'b0;
   logic [2:0]  a_opcode = '0;
   logic [2:0]  a_size = '0;
   logic [1:0]  a_source = '0;
   logic [29:0] a_address = '0;
   logic        d_valid = 1'b0, d_ready = 1'b0;
   logic [2:0]  d_opcode = '0;
   logic [2:0]  d_size = '0;
   logic [1:0]  d_source = '0;
   logic        err_valid;
   logic [3:0]  err_code;
   logic [8:0]  err_flags;
   logic [3:0]  inflight;
   logic        idle;

   tl_inflight_monitor #(.SOURCE_BITS(2), .SIZE_BITS(3), .ADDR_BITS(30),
                         .BEAT_LOG2(BEAT_LOG2), .TIMEOUT(TIMEOUT)) dut (
      .clock(clock), .reset(reset),
      .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_size(a_size),
      .a_source(a_source), .a_address(a_address),
      .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_size(d_size),
      .d_source(d_source),
      .err_valid(err_valid), .err_code(err_code), .err_flags(err_flags),
      .inflight(inflight), .idle(idle)
   );

   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Transaction-level reference: outstanding set, per-source request record, beats left per channel
   int   m_out[4], m_op[4], m_sz[4];
   int   m_a_left, m_d_left;
   int   m_a_first_op, m_a_first_sz, m_a_first_src;
   int   m_d_first_op, m_d_first_sz, m_d_first_src;
   int   m_a_stall, m_pa_op, m_pa_sz, m_pa_src, m_pa_addr;
   int   m_d_stall, m_pd_op, m_pd_sz, m_pd_src;
   int   m_wait;
   logic       ex_valid;
   logic [3:0] ex_code;
   logic [8:0] ex_flags;

   function automatic int beats(input int multi, input int sz);
      if (multi == 0 || sz <= BEAT_LOG2) return 1;
      return 1 << (sz - BEAT_LOG2);
   endfunction

   function automatic int n_out();
      return m_out[0] + m_out[1] + m_out[2] + m_out[3];
   endfunction

   task automatic model_step();
      bit [9:1] e;
      int afire, dfire, na, nd, dlast, busy, want;
      if (reset) begin
         for (int i = 0; i < 4; i++) begin m_out[i] = 0; m_op[i] = 0; m_sz[i] = 0; end
         m_a_left = 0; m_d_left = 0; m_a_stall = 0; m_d_stall = 0; m_wait = 0;
         ex_valid = 0; ex_code = 0; ex_flags = 0;
         return;
      end
      e     = '0;
      busy  = (n_out() != 0);
      afire = a_valid && a_ready;
      dfire = d_valid && d_ready;
      na    = beats(a_opcode == 0 || a_opcode == 1, a_size);
      nd    = beats(d_opcode == 1, d_size);
      dlast = (nd == 1) || (m_d_left == 1);
      if (afire && m_a_left == 0 && m_out[a_source] != 0) e[1] = 1;
      if (dfire && m_d_left == 0) begin
         if (m_out[d_source] == 0) e[2] = 1;
         else begin
            want = (m_op[d_source] == 4) ? 1 : 0;
            if (int'(d_opcode) != want) e[3] = 1;
            if (int'(d_size) != m_sz[d_source]) e[4] = 1;
         end
      end
      if (afire && (int'(a_address) % (1 << a_size)) != 0) e[5] = 1;
      if (m_a_stall != 0 && (!a_valid || int'(a_opcode) != m_pa_op || int'(a_size) != m_pa_sz ||
          int'(a_source) != m_pa_src || int'(a_address) != m_pa_addr)) e[6] = 1;
      if (m_d_stall != 0 && (!d_valid || int'(d_opcode) != m_pd_op || int'(d_size) != m_pd_sz ||
          int'(d_source) != m_pd_src)) e[7] = 1;
      if (afire && m_a_left != 0 && (int'(a_opcode) != m_a_first_op ||
          int'(a_size) != m_a_first_sz || int'(a_source) != m_a_first_src)) e[8] = 1;
      if (dfire && m_d_left != 0 && (int'(d_opcode) != m_d_first_op ||
          int'(d_size) != m_d_first_sz || int'(d_source) != m_d_first_src)) e[8] = 1;
      if (dfire || !busy) m_wait = 0;
      else if (m_wait < TIMEOUT) begin
         m_wait++;
         if (m_wait == TIMEOUT) e[9] = 1;
      end
      if (dfire) begin
         if (dlast) m_out[d_source] = 0;
         if (m_d_left == 0) begin
            m_d_left = nd - 1;
            m_d_first_op = d_opcode; m_d_first_sz = d_size; m_d_first_src = d_source;
         end else m_d_left--;
      end
      if (afire) begin
         if (m_a_left == 0) begin
            m_out[a_source] = 1; m_op[a_source] = a_opcode; m_sz[a_source] = a_size;
            m_a_left = na - 1;
            m_a_first_op = a_opcode; m_a_first_sz = a_size; m_a_first_src = a_source;
         end else m_a_left--;
      end
      m_a_stall = a_valid && !a_ready;
      m_pa_op = a_opcode; m_pa_sz = a_size; m_pa_src = a_source; m_pa_addr = a_address;
      m_d_stall = d_valid && !d_ready;
      m_pd_op = d_opcode; m_pd_sz = d_size; m_pd_src = d_source;
      ex_valid = (e != 0);
      ex_code  = 0;
      for (int c = 9; c >= 1; c--) if (e[c]) ex_code = 4'(c);
      ex_flags = ex_flags | e;
   endtask

   task automatic tick();
      logic [3:0] mi;
      model_step();
      @(posedge clock);
      @(negedge clock);
      for (int i = 0; i < 4; i++) mi[i] = (m_out[i] != 0);
      check("err_valid", 32'(err_valid), 32'(ex_valid));
      check("err_code", 32'(err_code), 32'(ex_code));
      check("err_flags", 32'(err_flags), 32'(ex_flags));
      check("inflight", 32'(inflight), 32'(mi));
      check("idle", 32'(idle), 32'(mi == 4'd0));
   endtask

   task automatic quiet();
      a_valid = 0; a_ready = 1; d_valid = 0; d_ready = 1;
   endtask

   task automatic do_reset();
      quiet();
      reset = 1; tick(); reset = 0;
   endtask

   task automatic send_a(input int op, input int sz, input int src, input int addr);
      a_valid = 1; a_ready = 1; a_opcode = 3'(op); a_size = 3'(sz);
      a_source = 2'(src); a_address = 30'(addr);
   endtask

   task automatic send_d(input int op, input int sz, input int src);
      d_valid = 1; d_ready = 1; d_opcode = 3'(op); d_size = 3'(sz); d_source = 2'(src);
   endtask

   task automatic gen_inputs();
      logic [29:0] mask;
      int s;
      reset = ($urandom_range(499) == 0);
      if (a_valid && !a_ready && $urandom_range(15) != 0) begin
      end else if (m_a_left > 0) begin
         a_valid  = ($urandom_range(3) != 0);
         a_opcode = 3'(m_a_first_op); a_size = 3'(m_a_first_sz); a_source = 2'(m_a_first_src);
         if ($urandom_range(31) == 0) a_size = a_size ^ 3'd1;
      end else begin
         a_valid = ($urandom_range(2) == 0);
         case ($urandom_range(2))
            0:       a_opcode = 3'd0;
            1:       a_opcode = 3'd1;
            default: a_opcode = 3'd4;
         endcase
         a_size = 3'($urandom_range(4));
         s = $urandom_range(3);
         for (int t = 0; t < 4 && m_out[s] != 0; t++) s = (s + 1) % 4;
         if ($urandom_range(15) == 0) s = $urandom_range(3);
         a_source  = 2'(s);
         mask      = (30'd1 << a_size) - 30'd1;
         a_address = 30'($urandom) & ~mask;
         if ($urandom_range(15) == 0) a_address = a_address | 30'd1;
      end
      a_ready = ($urandom_range(3) != 0);
      if (d_valid && !d_ready && $urandom_range(15) != 0) begin
      end else if (m_d_left > 0) begin
         d_valid  = ($urandom_range(3) != 0);
         d_opcode = 3'(m_d_first_op); d_size = 3'(m_d_first_sz); d_source = 2'(m_d_first_src);
         if ($urandom_range(31) == 0) d_size = d_size ^ 3'd1;
      end else begin
         s = $urandom_range(3);
         for (int t = 0; t < 4 && m_out[s] == 0; t++) s = (s + 1) % 4;
         d_valid  = ($urandom_range(2) == 0);
         d_source = 2'(s);
         if (m_out[s] != 0) begin
            d_opcode = (m_op[s] == 4) ? 3'd1 : 3'd0;
            d_size   = 3'(m_sz[s]);
         end else begin
            d_opcode = 3'($urandom_range(1));
            d_size   = 3'($urandom_range(4));
         end
         if ($urandom_range(15) == 0) d_opcode = d_opcode ^ 3'd1;
      end
      d_ready = ($urandom_range(3) != 0);
   endtask

   int pulses;
   logic [3:0] pulse_code;

   initial begin
      do_reset();
      check("rst_err_valid", 32'(err_valid), 32'd0);
      check("rst_flags", 32'(err_flags), 32'd0);
      check("rst_idle", 32'(idle), 32'd1);

      // Get then AccessAckData
      send_a(4, 2, 2, 'h40); tick();
      check("get_inflight", 32'(inflight), 32'b0100);
      quiet(); send_d(1, 2, 2); tick();
      check("get_idle", 32'(idle), 32'd1);
      check("get_flags", 32'(err_flags), 32'd0);

      // 4-beat PutFull with size change on beat 3
      do_reset();
      send_a(0, 4, 1, 'h100); tick();
      check("put_inflight1", 32'(inflight[1]), 32'd1);
      tick();
      a_size = 3'd3; tick();
      check("burst_valid", 32'(err_valid), 32'd1);
      check("burst_code", 32'(err_code), 32'd8);
      check("burst_flag7", 32'(err_flags[7]), 32'd1);
      a_size = 3'd4; tick();
      quiet(); send_d(0, 4, 1); tick();
      quiet();

      // duplicate source, then unknown-source D
      do_reset();
      send_a(4, 2, 0, 0); tick(); tick();
      check("dup_code", 32'(err_code), 32'd1);
      quiet(); send_d(0, 0, 3); tick();
      check("unk_code", 32'(err_code), 32'd2);
      check("unk_no34", 32'(err_flags[3:2]), 32'd0);
      quiet();

      // alignment and stability in the same cycle
      do_reset();
      send_a(4, 2, 1, 0); a_ready = 0; tick();
      a_ready = 1; a_address = 30'h2; tick();
      check("align_code", 32'(err_code), 32'd5);
      check("align_flags", 32'(err_flags[5:4]), 32'b11);
      quiet();

      // timeout fires once; a D while busy restarts the count
      do_reset();
      send_a(4, 2, 3, 0); tick(); quiet();
      pulses = 0; pulse_code = 0;
      for (int i = 0; i < TIMEOUT + 5; i++) begin
         tick();
         if (err_valid) begin pulses++; pulse_code = err_code; end
      end
      check("to_pulses", 32'(pulses), 32'd1);
      check("to_code", 32'(pulse_code), 32'd9);
      send_d(1, 2, 3); tick(); quiet();
      do_reset();
      send_a(4, 2, 2, 0); tick(); send_a(4, 2, 3, 0); tick(); quiet();
      pulses = 0;
      for (int i = 0; i < 900; i++) begin tick(); if (err_valid) pulses++; end
      send_d(1, 2, 2); tick(); quiet();
      for (int i = 0; i < 900; i++) begin tick(); if (err_valid) pulses++; end
      check("to_cleared", 32'(pulses), 32'd0);
      send_d(1, 2, 3); tick(); quiet();

      // reset mid-burst
      do_reset();
      send_a(0, 4, 0, 0); tick();
      reset = 1; tick(); reset = 0; quiet();
      check("mid_rst_valid", 32'(err_valid), 32'd0);
      check("mid_rst_code", 32'(err_code), 32'd0);
      check("mid_rst_flags", 32'(err_flags), 32'd0);
      check("mid_rst_inflight", 32'(inflight), 32'd0);
      check("mid_rst_idle", 32'(idle), 32'd1);
      send_a(4, 2, 1, 0); tick(); quiet();
      send_d(1, 2, 1); tick(); quiet();
      check("fresh_flags", 32'(err_flags), 32'd0);
      check("fresh_idle", 32'(idle), 32'd1);

      do_reset();
      for (int i = 0; i < 5000; i++) begin
         gen_inputs();
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/tl_inflight_monitor.md
TL_INFLIGHT_MONITOR -- requirements
Module: tl_inflight_monitor

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; the ports SHALL be named clock and reset.
REQ-002 Parameter: SOURCE_BITS, 2, source ID width; 2^SOURCE_BITS trackable sources.
REQ-003 Parameter: SIZE_BITS, 3, width of the log2 transfer-size field.
REQ-004 Parameter: ADDR_BITS, 30, address width.
REQ-005 Parameter: BEAT_LOG2, 2, log2 bytes per beat.
REQ-006 Parameter: TIMEOUT, 1024, cycles allowed with requests in flight and no D fire.
REQ-007 Ports:
clock  in  1  clock
reset  in  1  sync active-high reset
a_valid  in  1  A valid
a_ready  in  1  A ready
a_opcode  in  3  0=PutFull, 1=PutPartial, 4=Get
a_size  in  SIZE_BITS  log2 bytes
a_source  in  SOURCE_BITS  source ID
a_address  in  ADDR_BITS  byte address
d_valid  in  1  D valid
d_ready  in  1  D ready
d_opcode  in  3  0=AccessAck, 1=AccessAckData
d_size  in  SIZE_BITS  log2 bytes
d_source  in  SOURCE_BITS  source ID
err_valid  out  1  one-cycle error pulse
err_code  out  4  code of the reported error
err_flags  out  9  sticky per-code flags; bit n-1 = code n
inflight  out  2^SOURCE_BITS  per-source outstanding bitmap
idle  out  1  inflight == 0

Function
REQ-008 a_fire = a_valid & a_ready; d_fire = d_valid & d_ready.
REQ-009 Beat count: beats(size) = 2^(size-BEAT_LOG2) when size > BEAT_LOG2, else 1.
- A multi-beat: Put opcodes only.
- D multi-beat: AccessAckData only.
REQ-010 Per-channel beat counter:
- Counts remaining beats.
- Loads beats-1 on the first-beat fire and decrements on each later fire.
- A beat is first when the counter is 0; it is last when beats==1 or the counter is 1.
REQ-011 A-first-beat fire:
- Records opcode and size for a_source in a per-source table.
- Sets inflight[a_source] at the next edge.
REQ-012 D-last-beat fire clears inflight[d_source] at the next edge.
REQ-013 Same-cycle set and clear on the same source SHALL leave the bit set.
REQ-014 All checks SHALL use the registered state from the start of the cycle.
REQ-015 Error codes, raised on the offending fire or cycle:
- 1 A_DUP_SOURCE: A first beat on a source already in flight.
- 2 D_UNKNOWN_SOURCE: D first beat on a source not in flight.
- 3 D_OPCODE: D opcode mismatch (Get requires AccessAckData; Put requires AccessAck).
- 4 D_SIZE: d_size differs from the recorded size.
- 5 A_ALIGN: a_address not aligned to 2^a_size.
- 6 A_STABLE: the previous cycle had a_valid & !a_ready, and a_valid dropped or opcode/size/source/address changed.
- 7 D_STABLE: the same rule on D, covering opcode/size/source.
- 8 BURST_FIELD: a non-first beat's opcode/size/source differs from its first beat.
- 9 TIMEOUT: timeout counter reaches TIMEOUT.
REQ-016 Codes 3 and 4 SHALL be checked only when code 2 is not raised.
REQ-017 Timeout counter:
- Increments while idle==0 and !d_fire.
- Clears on d_fire or when idle.
- Saturates at TIMEOUT.
- Raises code 9 once per saturation.
REQ-018 Error reporting:
- err_valid and err_code SHALL be registered and appear one cycle after the offending cycle.
- When several errors occur in one cycle, err_code SHALL be the lowest code.
- Every error raised SHALL set its err_flags bit.
REQ-019 err_flags SHALL clear only on reset.
REQ-020 Tracking after an error: state updates SHALL continue as if the transfer were legal. Duplicate A overwrites the table entry; unknown-source D does not change inflight.
REQ-021 Protocol state SHALL be ignored in the reset cycle, and the stability history SHALL be cleared.

Reset
REQ-022 On reset, the following SHALL be 0 at the next edge: inflight, source table, beat counters, timeout counter, stability history, err_valid, err_code, err_flags. idle SHALL be 1.
REQ-023 Reset asserted mid-burst SHALL abandon the burst. The next A or D beat SHALL be treated as a first beat.

Verification
REQ-024 Get with source 2, size 2, address 0x40, then AccessAckData size 2 one cycle later:
- inflight = 0100 after the A.
- idle = 1 after the D.
- err_flags = 0.
REQ-025 PutFull with size 4 (4 beats), source 1:
- Third beat changes a_size to 3 -> err_code 8 one cycle later; bit 7 set.
- inflight[1] set.
REQ-026 Two Gets on source 0 back-to-back with no D -> err_code 1. D AccessAck on source 3 with source 3 idle -> err_code 2 with no code 3/4.
REQ-027 Same cycle: A_ALIGN (address 0x2, size 2) and A_STABLE -> err_code 5, flags bits 4 and 5 set.
REQ-028 Get outstanding, D held low for TIMEOUT cycles -> a single err_code 9 pulse. A later D clears the counter.
REQ-029 Reset asserted during the second beat of a 4-beat Put:
- All outputs are 0 and idle = 1.
- A fresh single-beat Get completes with no error.
